// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants for the mult/div issue controller: instruction field
// encodings, FSM state encoding, and default rstatus exception codes.
package multdiv_ctrl_pkg;

  // R-type ALU opcode and the two ALU_op values that route to the mult/div unit
  localparam logic [4:0] OPCODE_ALU = 5'b00000;
  localparam logic [4:0] ALU_OP_MUL = 5'b00110;
  localparam logic [4:0] ALU_OP_DIV = 5'b00111;

  // Default rstatus codes written on an exception
  localparam int MUL_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF = 5;
  localparam int TIMEOUT_EXC_CODE = 6;

  // Width of the busy-cycle debug probe
  localparam int BUSY_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // True when the instruction is an R-type mul or div
  function automatic logic is_multdiv_insn(input logic [31:0] insn);
    return (insn[31:27] == OPCODE_ALU) &&
           ((insn[6:2] == ALU_OP_MUL) || (insn[6:2] == ALU_OP_DIV));
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Clear/enable/saturating cycle counter. Also produces the watchdog compare,
// which is only live when MULTDIV_TIMEOUT_EN is defined.
module md_cycle_counter #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             limit_hit
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_reg;

  // Count enabled cycles; clear wins over enable, and the count sticks at all-ones
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

`ifdef MULTDIV_TIMEOUT_EN
  // Hit on the last permitted BUSY cycle so the FSM leaves BUSY after LIMIT cycles
  assign limit_hit = (count_reg == WIDTH'(LIMIT - 1));
`else
  assign limit_hit = 1'b0;
`endif

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle mult/div unit in the execute stage.
// Launches the unit from D/X, stalls the front of the pipe until the result
// returns, then injects the result (or an rstatus exception write) into X/M.
// Optional feature: define MULTDIV_TIMEOUT_EN to enable the BUSY watchdog.
module multdiv_issue_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_W          = 5,
  parameter int RSTATUS_REG    = 30,
  parameter int MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       insn_dx,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_operand_a,
  output logic [DATA_W-1:0] md_operand_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_result_rdy,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [REG_W-1:0]  result_rd,
  output logic [5:0]        busy_cycles
);

  md_state_e         state_reg;
  logic [DATA_W-1:0] op_a_reg;
  logic [DATA_W-1:0] op_b_reg;
  logic [REG_W-1:0]  rd_reg;
  logic              op_div_reg;
  logic [DATA_W-1:0] result_data_reg;
  logic [REG_W-1:0]  result_rd_reg;

  logic              insn_is_div;
  logic              start;
  logic              in_busy;
  logic              timeout_hit;
  logic              unused_insn_bits;

  // Only opcode, rd and ALU_op matter here; the rest of the word is ignored
  assign unused_insn_bits = ^{insn_dx[21:7], insn_dx[1:0]};

  assign insn_is_div = (insn_dx[6:2] == ALU_OP_DIV);
  assign in_busy     = (state_reg == ST_BUSY);

  // Reset is folded in so nothing launches or stalls while reset is held low
  assign start = reset && !flush && (state_reg == ST_IDLE) && is_multdiv_insn(insn_dx);

  // Stall is combinational so the issue cycle itself already freezes the front end
  assign stall        = start | in_busy;
  assign md_ctrl_mult = start & ~insn_is_div;
  assign md_ctrl_div  = start &  insn_is_div;

  // Forward live operands in the issue cycle (the unit samples them with the
  // start pulse), then hold the latched copy while the unit works
  assign md_operand_a = start ? operand_a : op_a_reg;
  assign md_operand_b = start ? operand_b : op_b_reg;

  // A flush arriving in DONE squashes the write into X/M
  assign result_valid = (state_reg == ST_DONE) && !flush;
  assign result_data  = result_data_reg;
  assign result_rd    = result_rd_reg;

  md_cycle_counter #(
    .WIDTH (BUSY_CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_busy_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (start),
    .enable    (in_busy),
    .count     (busy_cycles),
    .limit_hit (timeout_hit)
  );

  // Issue FSM: IDLE -> BUSY on start, BUSY -> DONE on result/timeout, DONE -> IDLE
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      rd_reg          <= '0;
      op_div_reg      <= 1'b0;
      result_data_reg <= '0;
      result_rd_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_BUSY;
            op_a_reg   <= operand_a;
            op_b_reg   <= operand_b;
            rd_reg     <= insn_dx[26:22];
            op_div_reg <= insn_is_div;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            // Squashed: any late ready from the unit is simply never looked at
            state_reg <= ST_IDLE;
          end else if (md_result_rdy) begin
            state_reg <= ST_DONE;
            if (md_exception) begin
              result_data_reg <= op_div_reg ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MUL_EXC_CODE);
              result_rd_reg   <= REG_W'(RSTATUS_REG);
            end else begin
              result_data_reg <= md_result;
              result_rd_reg   <= rd_reg;
            end
          end else if (timeout_hit) begin
            state_reg       <= ST_DONE;
            result_data_reg <= DATA_W'(TIMEOUT_EXC_CODE);
            result_rd_reg   <= REG_W'(RSTATUS_REG);
          end
        end
        ST_DONE: begin
          state_reg       <= ST_IDLE;
          result_data_reg <= '0;
          result_rd_reg   <= '0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: the driver queues the expected
// X/M write for each issued op, a monitor pops and compares on result_valid.
module tb_multdiv_issue_ctrl;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] A_MUL  = 5'b00110;
  localparam logic [4:0] A_DIV  = 5'b00111;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] insn_dx;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_result_rdy;
  logic        stall;
  logic        result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic [5:0]  busy_cycles;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  multdiv_issue_ctrl #(
    .DATA_W         (32),
    .REG_W          (5),
    .RSTATUS_REG    (30),
    .MUL_EXC_CODE   (4),
    .DIV_EXC_CODE   (5),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .insn_dx       (insn_dx),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .flush         (flush),
    .md_ctrl_mult  (md_ctrl_mult),
    .md_ctrl_div   (md_ctrl_div),
    .md_operand_a  (md_operand_a),
    .md_operand_b  (md_operand_b),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_result_rdy (md_result_rdy),
    .stall         (stall),
    .result_valid  (result_valid),
    .result_data   (result_data),
    .result_rd     (result_rd),
    .busy_cycles   (busy_cycles)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mk_insn(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] alu);
    return {op, rd, 15'd0, alu, 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Monitor: every X/M injection must match the oldest queued expectation
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got rd=%0d data=%0d, required no result", result_rd, result_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_rd", 32'(result_rd), 32'(mon_e.rd));
        check("result_data", result_data, mon_e.data);
        $display("result rd=%0d data=%0d (expected rd=%0d data=%0d)", result_rd, result_data, mon_e.rd, mon_e.data);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      insn_dx = 32'h0; flush = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0; md_result = 32'h0;
    end
  endtask

  // Issue one op; the unit answers k cycles after issue. flush_off != 0 flushes
  // in that cycle after issue (no result expected).
  task automatic run_op(input string tag, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int k, input bit give_rdy, input logic exc,
                        input logic [31:0] res, input int flush_off, input logic [4:0] exp_rd,
                        input logic [31:0] exp_data);
    int   stalls;
    bit   is_div;
    exp_t e;
    stalls = 0;
    is_div = (insn[6:2] == A_DIV);
    @(posedge clock); #1;
    insn_dx = insn; operand_a = a; operand_b = b;
    flush = 1'b0; md_result_rdy = 1'b0; md_exception = 1'b0; md_result = 32'h0;
    if (flush_off == 0) begin
      e.rd = exp_rd; e.data = exp_data;
      exp_q.push_back(e);
    end
    @(negedge clock);
    $display("issue %s a=%0d b=%0d k=%0d", tag, a, b, k);
    check({tag, " ctrl_mult"}, 32'(md_ctrl_mult), 32'(!is_div));
    check({tag, " ctrl_div"}, 32'(md_ctrl_div), 32'(is_div));
    check({tag, " md_operand_a"}, md_operand_a, a);
    stalls += int'(stall);
    for (int c = 1; c <= k + 1; c++) begin
      @(posedge clock); #1;
      operand_a = 32'hdead_beef; operand_b = 32'h1234_5678;
      md_result_rdy = give_rdy && (c == k);
      md_exception  = give_rdy && exc && (c == k);
      md_result     = (c == k) ? res : 32'h0;
      flush         = (c == flush_off);
      if (flush_off != 0 && c == flush_off + 1) insn_dx = 32'h0;
      @(negedge clock);
      stalls += int'(stall);
      if (c == 1) begin
        check({tag, " latched_a"}, md_operand_a, a);
        check({tag, " latched_b"}, md_operand_b, b);
        check({tag, " no_reissue"}, 32'(md_ctrl_mult | md_ctrl_div), 32'd0);
      end
      if (flush_off != 0 && c == flush_off + 1)
        check({tag, " stall_after_flush"}, 32'(stall), 32'd0);
      if (flush_off == 0 && c == k + 1)
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(k > 63 ? 63 : k));
    end
    check({tag, " stall_cycles"}, 32'(stalls), 32'(flush_off != 0 ? flush_off + 1 : k + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; insn_dx = 32'h0; operand_a = 32'h0; operand_b = 32'h0; flush = 1'b0;
    md_result = 32'h0; md_exception = 1'b0; md_result_rdy = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst stall", 32'(stall), 32'd0);
    check("rst result_valid", 32'(result_valid), 32'd0);
    check("rst busy_cycles", 32'(busy_cycles), 32'd0);
    check("rst md_operand_a", md_operand_a, 32'd0);
    @(posedge clock); #1; reset = 1'b1;

    // Non-mul/div ALU op and non-ALU opcode must not stall
    idle(1);
    insn_dx = mk_insn(OP_ALU, 5'd4, 5'b00000);
    @(negedge clock); check("add no_stall", 32'(stall), 32'd0);
    @(posedge clock); #1; insn_dx = mk_insn(5'b00101, 5'd4, A_MUL);
    @(negedge clock); check("addi no_stall", 32'(stall), 32'd0);
    // flush in IDLE blocks issue
    @(posedge clock); #1; insn_dx = mk_insn(OP_ALU, 5'd4, A_MUL); flush = 1'b1;
    @(negedge clock);
    check("flush_idle stall", 32'(stall), 32'd0);
    check("flush_idle ctrl", 32'(md_ctrl_mult), 32'd0);
    idle(1);

    // Test 1: plain multiply, 16-cycle unit latency
    run_op("mul1", mk_insn(OP_ALU, 5'd3, A_MUL), 32'd7, 32'd6, 16, 1'b1, 1'b0, 32'd42, 0, 5'd3, 32'd42);
    idle(2);
    // Test 2: divide by zero and multiply overflow
    run_op("div0", mk_insn(OP_ALU, 5'd5, A_DIV), 32'd10, 32'd0, 3, 1'b1, 1'b1, 32'd0, 0, 5'd30, 32'd5);
    idle(1);
    run_op("mulovf", mk_insn(OP_ALU, 5'd6, A_MUL), 32'h7fff_ffff, 32'd2, 2, 1'b1, 1'b1, 32'hffff_fffe, 0, 5'd30, 32'd4);
    idle(1);
    // Test 3: flush three cycles after issue, late ready ignored
    run_op("flush", mk_insn(OP_ALU, 5'd8, A_MUL), 32'd2, 32'd3, 8, 1'b1, 1'b0, 32'd6, 3, 5'd8, 32'd6);
    idle(2);
    // Test 4: back-to-back mul then div, second issue in the cycle after DONE
    run_op("b2b_mul", mk_insn(OP_ALU, 5'd10, A_MUL), 32'd9, 32'd4, 4, 1'b1, 1'b0, 32'd36, 0, 5'd10, 32'd36);
    run_op("b2b_div", mk_insn(OP_ALU, 5'd11, A_DIV), 32'd100, 32'd7, 5, 1'b1, 1'b0, 32'd14, 0, 5'd11, 32'd14);
    idle(2);

    // Test 5: reset mid-BUSY drops the op and clears every output
    @(posedge clock); #1;
    insn_dx = mk_insn(OP_ALU, 5'd9, A_MUL); operand_a = 32'd11; operand_b = 32'd13;
    @(negedge clock); check("rstmid issue_stall", 32'(stall), 32'd1);
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    @(posedge clock); #1; reset = 1'b1; insn_dx = 32'h0;
    @(negedge clock);
    $display("reset mid-busy applied");
    check("rstmid stall", 32'(stall), 32'd0);
    check("rstmid ctrl_mult", 32'(md_ctrl_mult), 32'd0);
    check("rstmid ctrl_div", 32'(md_ctrl_div), 32'd0);
    check("rstmid result_valid", 32'(result_valid), 32'd0);
    check("rstmid result_data", result_data, 32'd0);
    check("rstmid result_rd", 32'(result_rd), 32'd0);
    check("rstmid md_operand_a", md_operand_a, 32'd0);
    check("rstmid md_operand_b", md_operand_b, 32'd0);
    check("rstmid busy_cycles", 32'(busy_cycles), 32'd0);
    run_op("post_rst", mk_insn(OP_ALU, 5'd7, A_MUL), 32'd3, 32'd5, 1, 1'b1, 1'b0, 32'd15, 0, 5'd7, 32'd15);
    idle(2);

`ifdef MULTDIV_TIMEOUT_EN
    // Test 6: unit never answers; watchdog fires after 8 BUSY cycles
    run_op("timeout", mk_insn(OP_ALU, 5'd12, A_DIV), 32'd1, 32'd1, 8, 1'b0, 1'b0, 32'd0, 0, 5'd30, 32'd6);
    idle(2);
`endif

    idle(3);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
